// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: exception/interrupt sequencer sitting in front of the CP0
// register file. It synchronises the external interrupt lines, picks the
// highest-priority event from the memory stage, and issues a one-cycle
// exception command to CP0. It then drives the pipeline flush and redirect PC
// and ignores new events until the flush window has elapsed.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_raw_i,
  output logic [5:0]  int_sync_o,
  input  logic        mem_valid_i,
  input  logic        exc_invalid_i,
  input  logic        exc_syscall_i,
  input  logic        exc_trap_i,
  input  logic        exc_eret_i,
  input  logic [31:0] inst_addr_i,
  input  logic        in_delayslot_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic [31:0] epc_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] cp0_inst_addr_o,
  output logic        cp0_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  localparam logic [31:0] CODE_NONE    = 32'h0000_0000;
  localparam logic [31:0] CODE_INT     = 32'h0000_0001;
  localparam logic [31:0] CODE_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] CODE_INVALID = 32'h0000_000a;
  localparam logic [31:0] CODE_TRAP    = 32'h0000_000d;
  localparam logic [31:0] CODE_ERET    = 32'h0000_000e;

  // The counter reloads with FLUSH_CYCLES-1 so that flush spans FLUSH_CYCLES cycles.
  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Fixed-priority pick of one event; lower-priority flags are dropped.
  function automatic logic [31:0] pick_code(
    input logic pend,
    input logic invalid,
    input logic syscall,
    input logic trap,
    input logic eret
  );
    logic [31:0] code;
    if (pend) begin
      code = CODE_INT;
    end else if (invalid) begin
      code = CODE_INVALID;
    end else if (syscall) begin
      code = CODE_SYSCALL;
    end else if (trap) begin
      code = CODE_TRAP;
    end else if (eret) begin
      code = CODE_ERET;
    end else begin
      code = CODE_NONE;
    end
    return code;
  endfunction

  state_t      state_r, state_nx;
  logic [3:0]  cnt_r, cnt_nx;
  logic [5:0]  sync1_r, sync2_r;
  logic [31:0] exctype_r, exctype_nx;
  logic [31:0] addr_r, addr_nx;
  logic        ds_r, ds_nx;
  logic        flush_r, flush_nx;
  logic [31:0] pc_r, pc_nx;
  logic        int_pend_s;
  logic [31:0] code_s;
  logic        unused_s;

  // Only IE, EXL and the interrupt-mask/pending fields matter here.
  assign unused_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

  // An interrupt is pending when IE=1, EXL=0 and some enabled line is pending.
  assign int_pend_s = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign code_s     = pick_code(int_pend_s, exc_invalid_i, exc_syscall_i, exc_trap_i, exc_eret_i);

  // Two-flop synchroniser per interrupt line, free-running in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 6'd0;
      sync2_r <= 6'd0;
    end else begin
      sync1_r <= int_raw_i;
      sync2_r <= sync1_r;
    end
  end

  // Next-state and next-output logic for the IDLE/FLUSH sequencer.
  always_comb begin
    state_nx   = state_r;
    cnt_nx     = cnt_r;
    exctype_nx = CODE_NONE;
    addr_nx    = addr_r;
    ds_nx      = ds_r;
    flush_nx   = flush_r;
    pc_nx      = pc_r;
    case (state_r)
      IDLE: begin
        if (mem_valid_i && (code_s != CODE_NONE)) begin
          exctype_nx = code_s;
          addr_nx    = inst_addr_i;
          ds_nx      = in_delayslot_i;
          pc_nx      = (code_s == CODE_ERET) ? epc_i : EXC_VECTOR;
          flush_nx   = 1'b1;
          cnt_nx     = CNT_INIT;
          state_nx   = FLUSH;
        end else begin
          flush_nx   = 1'b0;
        end
      end
      FLUSH: begin
        // Inputs here belong to flushed instructions, and EXL needs a cycle to settle.
        if (cnt_r == 4'd0) begin
          flush_nx = 1'b0;
          state_nx = IDLE;
        end else begin
          cnt_nx   = cnt_r - 4'd1;
        end
      end
      default: begin
        flush_nx = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs; reset aborts any flush at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      exctype_r <= CODE_NONE;
      addr_r    <= 32'd0;
      ds_r      <= 1'b0;
      flush_r   <= 1'b0;
      pc_r      <= 32'd0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      exctype_r <= exctype_nx;
      addr_r    <= addr_nx;
      ds_r      <= ds_nx;
      flush_r   <= flush_nx;
      pc_r      <= pc_nx;
    end
  end

  assign int_sync_o      = sync2_r;
  assign excepttype_o    = exctype_r;
  assign cp0_inst_addr_o = addr_r;
  assign cp0_delayslot_o = ds_r;
  assign flush_o         = flush_r;
  assign new_pc_o        = pc_r;
  assign busy_o          = (state_r != IDLE);

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed testbench for cp0_exc_ctrl with hand-computed expectations.
module tb_cp0_exc_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  int_raw_i;
  logic [5:0]  int_sync_o;
  logic        mem_valid_i;
  logic        exc_invalid_i;
  logic        exc_syscall_i;
  logic        exc_trap_i;
  logic        exc_eret_i;
  logic [31:0] inst_addr_i;
  logic        in_delayslot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] cp0_inst_addr_o;
  logic        cp0_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  cp0_exc_ctrl #(
    .EXC_VECTOR  (32'h0000_0020),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .int_raw_i      (int_raw_i),
    .int_sync_o     (int_sync_o),
    .mem_valid_i    (mem_valid_i),
    .exc_invalid_i  (exc_invalid_i),
    .exc_syscall_i  (exc_syscall_i),
    .exc_trap_i     (exc_trap_i),
    .exc_eret_i     (exc_eret_i),
    .inst_addr_i    (inst_addr_i),
    .in_delayslot_i (in_delayslot_i),
    .status_i       (status_i),
    .cause_i        (cause_i),
    .epc_i          (epc_i),
    .excepttype_o   (excepttype_o),
    .cp0_inst_addr_o(cp0_inst_addr_o),
    .cp0_delayslot_o(cp0_delayslot_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .busy_o         (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    mem_valid_i    = 1'b0;
    exc_invalid_i  = 1'b0;
    exc_syscall_i  = 1'b0;
    exc_trap_i     = 1'b0;
    exc_eret_i     = 1'b0;
    in_delayslot_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    int_raw_i   = 6'd0;
    inst_addr_i = 32'd0;
    status_i    = 32'd0;
    cause_i     = 32'd0;
    epc_i       = 32'd0;
    clear_flags();
    tick();
    tick();

    // Reset state.
    chk("rst_exctype", excepttype_o, 32'h0);
    chk("rst_flush", {31'd0, flush_o}, 32'h0);
    chk("rst_busy", {31'd0, busy_o}, 32'h0);
    chk("rst_newpc", new_pc_o, 32'h0);
    chk("rst_addr", cp0_inst_addr_o, 32'h0);
    chk("rst_sync", {26'd0, int_sync_o}, 32'h0);
    rst = 1'b0;
    tick();

    // Syscall accepted at cycle N.
    status_i      = 32'h1000_0000;
    mem_valid_i   = 1'b1;
    exc_syscall_i = 1'b1;
    inst_addr_i   = 32'h0000_0104;
    tick();
    clear_flags();
    chk("sys_n1_exctype", excepttype_o, 32'h8);
    chk("sys_n1_flush", {31'd0, flush_o}, 32'h1);
    chk("sys_n1_busy", {31'd0, busy_o}, 32'h1);
    chk("sys_n1_newpc", new_pc_o, 32'h20);
    chk("sys_n1_addr", cp0_inst_addr_o, 32'h104);
    tick();
    chk("sys_n2_exctype", excepttype_o, 32'h0);
    chk("sys_n2_flush", {31'd0, flush_o}, 32'h1);
    tick();
    chk("sys_n3_flush", {31'd0, flush_o}, 32'h0);
    chk("sys_n3_busy", {31'd0, busy_o}, 32'h0);
    chk("sys_n3_addr_hold", cp0_inst_addr_o, 32'h104);

    // Interrupt beats simultaneous trap; delay-slot flag is latched.
    status_i       = 32'h0000_0401;
    cause_i        = 32'h0000_0400;
    mem_valid_i    = 1'b1;
    exc_trap_i     = 1'b1;
    in_delayslot_i = 1'b1;
    inst_addr_i    = 32'h0000_0300;
    tick();
    clear_flags();
    chk("int_exctype", excepttype_o, 32'h1);
    chk("int_ds", {31'd0, cp0_delayslot_o}, 32'h1);
    chk("int_addr", cp0_inst_addr_o, 32'h300);
    chk("int_newpc", new_pc_o, 32'h20);
    tick();
    tick();
    chk("int_done_busy", {31'd0, busy_o}, 32'h0);

    // Same with EXL set: interrupt masked, trap wins.
    status_i    = 32'h0000_0403;
    mem_valid_i = 1'b1;
    exc_trap_i  = 1'b1;
    inst_addr_i = 32'h0000_0310;
    tick();
    clear_flags();
    chk("exl_trap_exctype", excepttype_o, 32'hd);
    chk("exl_trap_ds", {31'd0, cp0_delayslot_o}, 32'h0);
    tick();
    tick();

    // EXL with only an interrupt pending: nothing taken.
    mem_valid_i = 1'b1;
    tick();
    clear_flags();
    chk("exl_int_exctype", excepttype_o, 32'h0);
    chk("exl_int_flush", {31'd0, flush_o}, 32'h0);

    // mem_valid low: flags ignored.
    status_i      = 32'h0000_0000;
    cause_i       = 32'h0000_0000;
    exc_invalid_i = 1'b1;
    tick();
    clear_flags();
    chk("novalid_busy", {31'd0, busy_o}, 32'h0);
    chk("novalid_exctype", excepttype_o, 32'h0);

    // Eret redirects to EPC.
    status_i    = 32'h0000_0002;
    epc_i       = 32'h0000_0200;
    mem_valid_i = 1'b1;
    exc_eret_i  = 1'b1;
    tick();
    clear_flags();
    chk("eret_exctype", excepttype_o, 32'he);
    chk("eret_newpc", new_pc_o, 32'h200);
    tick();
    tick();
    chk("eret_newpc_hold", new_pc_o, 32'h200);
    chk("eret_flush_end", {31'd0, flush_o}, 32'h0);

    // Holdoff: invalid held for cycles 0..5, acceptances at 0 and 3.
    status_i      = 32'h0000_0000;
    mem_valid_i   = 1'b1;
    exc_invalid_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("hold_busy_c%0d", c), {31'd0, busy_o},
          (c == 3) ? 32'h0 : 32'h1);
      chk($sformatf("hold_exctype_c%0d", c), excepttype_o,
          (c == 1 || c == 4) ? 32'ha : 32'h0);
    end
    clear_flags();
    tick();
    chk("hold_idle", {31'd0, busy_o}, 32'h0);

    // Reset mid-flush aborts immediately, no residual flush.
    status_i      = 32'h1000_0000;
    mem_valid_i   = 1'b1;
    exc_syscall_i = 1'b1;
    inst_addr_i   = 32'h0000_0400;
    tick();
    clear_flags();
    chk("rmf_pre_flush", {31'd0, flush_o}, 32'h1);
    rst = 1'b1;
    #1;
    chk("rmf_flush", {31'd0, flush_o}, 32'h0);
    chk("rmf_exctype", excepttype_o, 32'h0);
    chk("rmf_busy", {31'd0, busy_o}, 32'h0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("rmf_post_flush_%0d", c), {31'd0, flush_o}, 32'h0);
    end

    // Synchroniser: two-edge latency.
    int_raw_i = 6'b100001;
    tick();
    chk("sync_1edge", {26'd0, int_sync_o}, 32'h0);
    tick();
    chk("sync_2edge", {26'd0, int_sync_o}, 32'h21);
    int_raw_i = 6'b000000;
    tick();
    chk("sync_fall_1edge", {26'd0, int_sync_o}, 32'h21);
    tick();
    chk("sync_fall_2edge", {26'd0, int_sync_o}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
